// File: rtl/divgen_pkg.sv
// Shared definitions for the sequential restoring divider.
package divgen_pkg;

    // Operand/result width used when no override is given.
    localparam int unsigned DEFAULT_WIDTH = 32;

    // Controller phases: idle, one quotient bit per RUN cycle, sign fixup, result pulse.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // Quotient reported for a zero divisor (every bit set).
    localparam logic [DEFAULT_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/divgen_seq_if.sv
// Request/result bundle of the divider: start handshake, operands, results.
interface divgen_seq_if
    import divgen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    // Requester side (execution cluster issue logic / testbench).
    modport master (
        output start, sgn, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    // Divider side.
    modport slave (
        input  start, sgn, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/divgen_step.sv
// Combinational single-bit restoring division stage.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor through a WIDTH+1-bit ripple of full adders and either keeps the
// difference (quotient bit 1) or restores the shifted remainder (quotient bit 0).
module divgen_step
    import divgen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-2:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   subtrahend;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] carry;

    // The running remainder never reaches 2^(WIDTH-1) before a shift (it is
    // bounded by the dividend prefix consumed so far), so its MSB can be dropped.
    assign partial    = {1'b0, rem_in, dvd_bit};
    assign subtrahend = ~{1'b0, divisor};
    assign carry[0]   = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        mulgen_FA u_fa (
            .a    (partial[i]),
            .b    (subtrahend[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Carry out of the subtract means no borrow: the difference is non-negative.
    assign q_bit   = carry[WIDTH+1];
    assign rem_out = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/mulgen_FA.sv
// One-bit full adder primitive shared with the multiplier generator.
module mulgen_FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/divgen_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned, start/done handshake.
// Magnitudes are divided; signs are applied in a single fixup cycle at the end.
module divgen_seq
    import divgen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    divgen_seq_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign dividend_neg = bus.sgn & bus.dividend[WIDTH-1];
    assign divisor_neg  = bus.sgn & bus.divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -bus.dividend : bus.dividend;
    assign divisor_mag  = divisor_neg ? -bus.divisor : bus.divisor;

    divgen_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem[WIDTH-2:0]),
        .divisor (dsr),
        .dvd_bit (dvd[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;

    // Controller, shift registers, sign fixup and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            quo    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_neg  <= dividend_neg ^ divisor_neg;
                        r_neg  <= dividend_neg;
                        dsr    <= divisor_mag;
                        rem    <= '0;
                        quo    <= '0;
                        count  <= CW'(WIDTH);
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Raw dividend is kept so it can be returned as the remainder.
                            dz    <= 1'b1;
                            dvd   <= bus.dividend;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            dvd   <= dividend_mag;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= step_rem;
                    quo   <= {quo[WIDTH-2:0], step_q};
                    dvd   <= {dvd[WIDTH-2:0], 1'b0};
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quo_q <= {WIDTH{DZ_QUOTIENT[0]}};
                        rem_q <= dvd;
                        dz_q  <= 1'b1;
                    end else begin
                        quo_q <= q_neg ? -quo : quo;
                        rem_q <= r_neg ? -rem : rem;
                        dz_q  <= 1'b0;
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divgen_seq.sv
// Self-checking bench for divgen_seq: arithmetic reference model compared every
// cycle, plus hand-computed result/latency literals for each directed operation.
module tb_divgen_seq;

    localparam int unsigned W = 32;
    localparam int NOPS = 10;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    // Directed operations that must complete, with hand-computed expectations.
    localparam logic [31:0] T_A [NOPS] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                                           32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'd9, 32'hFFFF_FF9C};
    localparam logic [31:0] T_B [NOPS] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                                           32'hFFFF_FFFF, 32'd1, 32'd7, 32'd3, 32'd7};
    localparam logic        T_S [NOPS] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] T_Q [NOPS] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                           32'h8000_0000, 32'hFFFF_FFFF, 32'd14, 32'd3, 32'hFFFF_FFF2};
    localparam logic [31:0] T_R [NOPS] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5,
                                           32'd0, 32'd0, 32'd2, 32'd0, 32'hFFFF_FFFE};
    localparam logic        T_DZ [NOPS] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int          T_LAT [NOPS] = '{34, 34, 34, 2, 2, 34, 34, 34, 34, 34};

    logic clk = 1'b0;
    logic rst = 1'b1;

    divgen_seq_if #(.WIDTH(W)) bus ();

    divgen_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state (written only by the model process).
    int          cyc = 0;
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_acc_cyc = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic        m_dz = 1'b0;
    res_t        pend;

    // Stimulus-to-checker requests (written only by the stimulus process).
    int timeouts = 0;
    int zero_req = 0;
    bit final_req = 1'b0;

    // Checker-owned bookkeeping.
    int zero_ack = 0;
    bit final_ack = 1'b0;
    int op_idx = 0;
    int busy_run = 0;

    function automatic res_t model_div(logic s, logic [31:0] a, logic [31:0] b);
        res_t   o;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            o.q  = '1;
            o.r  = a;
            o.dz = 1'b1;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            o.q  = 32'(sa / sb);
            o.r  = 32'(sa % sb);
            o.dz = 1'b0;
        end else begin
            o.q  = a / b;
            o.r  = a % b;
            o.dz = 1'b0;
        end
        return o;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: accepted request, fixed latency, arithmetic result.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_phase = 0;
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_q     = '0;
                m_r     = '0;
                m_dz    = 1'b0;
            end else begin
                case (m_phase)
                    0: begin
                        if (bus.start === 1'b1) begin
                            pend      = model_div(bus.sgn, bus.dividend, bus.divisor);
                            m_cnt     = pend.dz ? 1 : int'(W) + 1;
                            m_phase   = 1;
                            m_busy    = 1'b1;
                            m_acc_cyc = cyc;
                        end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            m_phase = 2;
                            m_busy  = 1'b0;
                            m_done  = 1'b1;
                            m_q     = pend.q;
                            m_r     = pend.r;
                            m_dz    = pend.dz;
                        end
                    end
                    default: begin
                        m_done  = 1'b0;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Compare process: DUT against model each cycle, literals on each done.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("quotient", bus.quotient, m_q);
            chk("remainder", bus.remainder, m_r);
            chk("div_zero", 32'(bus.div_zero), 32'(m_dz));
            if (bus.done === 1'b1) begin
                if (op_idx < NOPS) begin
                    chk("lit_quotient", bus.quotient, T_Q[op_idx]);
                    chk("lit_remainder", bus.remainder, T_R[op_idx]);
                    chk("lit_div_zero", 32'(bus.div_zero), 32'(T_DZ[op_idx]));
                    chk("lit_latency", 32'(cyc - m_acc_cyc + 1), 32'(T_LAT[op_idx]));
                    chk("lit_busy_cycles", 32'(busy_run), 32'(T_LAT[op_idx] - 1));
                end else begin
                    chk("unexpected_done", 32'(op_idx + 1), 32'(NOPS));
                end
                op_idx++;
                busy_run = 0;
            end else if (bus.busy === 1'b1) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
            if (zero_req != zero_ack) begin
                zero_ack = zero_req;
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_quotient", bus.quotient, 32'd0);
                chk("rst_remainder", bus.remainder, 32'd0);
                chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
            end
            if (final_req && !final_ack) begin
                chk("done_pulses", 32'(op_idx), 32'(NOPS));
                chk("timeouts", 32'(timeouts), 32'd0);
                final_ack = 1'b1;
            end
        end
    end

    task automatic launch(input int i);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.sgn      = T_S[i];
        bus.dividend = T_A[i];
        bus.divisor  = T_B[i];
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!got) begin
                @(negedge clk);
                if (bus.done === 1'b1) got = 1'b1;
            end
        end
        if (!got) timeouts++;
    endtask

    // Stimulus: directed operations, start-while-busy, reset mid-operation.
    initial begin
        bus.start    = 1'b0;
        bus.sgn      = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        zero_req++;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(i);
            wait_done();
        end

        // 100 / 7 with an ignored 9 / 3 request arriving mid-run.
        launch(7);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.sgn      = 1'b0;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // 100 / 7 aborted by reset ten cycles after acceptance; no done may follow.
        launch(7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        zero_req++;
        repeat (50) @(negedge clk);

        launch(8);
        wait_done();
        launch(9);
        wait_done();

        repeat (3) @(negedge clk);
        final_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!final_ack) @(negedge clk);
        end
        if (!final_ack) begin
            $display("FAIL final_check: got no acknowledge expected acknowledge");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
